// File: rtl/pmu_spi_pkg.sv
// Shared types and default sizing for the PMU SPI arbiter and its driver.
package pmu_spi_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  localparam int          NUM_REQ_DEF        = 4;
  localparam int          DATA_WITH_DEF      = 29;
  localparam int          READ_DATA_WITH_DEF = 29;
  localparam logic [15:0] TIMEOUT_DEF        = 16'd4096;
  localparam int          IDX_W              = $clog2(NUM_REQ_DEF);

  function automatic int idx_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/pmu_spi_arbiter_if.sv
// Requester-side and driver-side signals of the PMU SPI arbiter.
interface pmu_spi_arbiter_if #(
  parameter int NUM_REQ        = pmu_spi_pkg::NUM_REQ_DEF,
  parameter int DATA_WITH      = pmu_spi_pkg::DATA_WITH_DEF,
  parameter int READ_DATA_WITH = pmu_spi_pkg::READ_DATA_WITH_DEF
) ();
  import pmu_spi_pkg::*;

  logic [NUM_REQ-1:0]           req;
  logic [NUM_REQ-1:0]           req_rd;
  logic [NUM_REQ*DATA_WITH-1:0] req_data;
  logic [NUM_REQ-1:0]           gnt;
  logic [NUM_REQ-1:0]           done;
  logic [READ_DATA_WITH-1:0]    resp_data;
  logic [READ_DATA_WITH-1:0]    resp_data_b;
  logic                         resp_err;
  logic                         busy;
  logic                         spi_wr_req;
  logic                         spi_rd_req;
  logic [DATA_WITH-1:0]         spi_data;
  logic                         spi_ready;
  logic                         spi_wr_done;
  logic [READ_DATA_WITH-1:0]    spi_rd_data;
  logic [READ_DATA_WITH-1:0]    spi_rd_data_b;
  logic                         spi_rd_data_vld;

  modport slave (
    input  req, req_rd, req_data, spi_ready, spi_wr_done,
           spi_rd_data, spi_rd_data_b, spi_rd_data_vld,
    output gnt, done, resp_data, resp_data_b, resp_err, busy,
           spi_wr_req, spi_rd_req, spi_data
  );

  modport master (
    output req, req_rd, req_data, spi_ready, spi_wr_done,
           spi_rd_data, spi_rd_data_b, spi_rd_data_vld,
    input  gnt, done, resp_data, resp_data_b, resp_err, busy,
           spi_wr_req, spi_rd_req, spi_data
  );

endinterface

// File: rtl/pmu_spi_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request above ptr, wrapping.
module pmu_rr_pick
  import pmu_spi_pkg::*;
#(
  parameter int NUM_REQ = NUM_REQ_DEF,
  localparam int IW = idx_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IW-1:0]      ptr_i,
  output logic               any_o,
  output logic [IW-1:0]      idx_o
);

  int            cand_s;
  logic [IW-1:0] cidx_s;

  // Walk offsets from farthest to nearest so the nearest set bit is the last write.
  always_comb begin
    any_o  = |req_i;
    idx_o  = '0;
    cand_s = 0;
    cidx_s = '0;
    for (int off = NUM_REQ; off >= 1; off--) begin
      cand_s = (int'(ptr_i) + off) % NUM_REQ;
      cidx_s = IW'(cand_s);
      idx_o  = req_i[cidx_s] ? cidx_s : idx_o;
    end
  end

endmodule

// File: rtl/pmu_spi_arbiter.sv
// Round-robin arbiter sharing one CPHA=0 SPI master driver between PMU requesters.
module pmu_spi_arbiter
  import pmu_spi_pkg::*;
#(
  parameter int          NUM_REQ        = NUM_REQ_DEF,
  parameter int          DATA_WITH      = DATA_WITH_DEF,
  parameter int          READ_DATA_WITH = READ_DATA_WITH_DEF,
  parameter logic [15:0] TIMEOUT        = TIMEOUT_DEF
) (
  input logic              clk,
  input logic              rst,
  pmu_spi_arbiter_if.slave bus
);

  localparam int IW = idx_width(NUM_REQ);
  localparam logic [NUM_REQ-1:0] ONE_HOT0 = {{(NUM_REQ-1){1'b0}}, 1'b1};

  state_e                    state_q;
  logic [IW-1:0]             ptr_q;
  logic [IW-1:0]             idx_q;
  logic                      rd_q;
  logic [15:0]               cnt_q;
  logic [15:0]               cnt_d;
  logic [NUM_REQ-1:0]        gnt_q;
  logic [NUM_REQ-1:0]        done_q;
  logic [READ_DATA_WITH-1:0] resp_data_q;
  logic [READ_DATA_WITH-1:0] resp_data_b_q;
  logic                      resp_err_q;
  logic                      busy_q;
  logic                      spi_wr_req_q;
  logic                      spi_rd_req_q;
  logic [DATA_WITH-1:0]      spi_data_q;
  logic                      pick_any_d;
  logic [IW-1:0]             pick_idx_d;
  logic                      cmpl_s;

  pmu_rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
    .req_i (bus.req),
    .ptr_i (ptr_q),
    .any_o (pick_any_d),
    .idx_o (pick_idx_d)
  );

  assign cnt_d  = cnt_q + 16'd1;
  // Only the completion matching the issued frame type ends the wait.
  assign cmpl_s = rd_q ? bus.spi_rd_data_vld : bus.spi_wr_done;

  assign bus.gnt         = gnt_q;
  assign bus.done        = done_q;
  assign bus.resp_data   = resp_data_q;
  assign bus.resp_data_b = resp_data_b_q;
  assign bus.resp_err    = resp_err_q;
  assign bus.busy        = busy_q;
  assign bus.spi_wr_req  = spi_wr_req_q;
  assign bus.spi_rd_req  = spi_rd_req_q;
  assign bus.spi_data    = spi_data_q;

  // Arbitration FSM with all outputs held in registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      ptr_q         <= IW'(NUM_REQ - 1);
      idx_q         <= '0;
      rd_q          <= 1'b0;
      cnt_q         <= 16'd0;
      gnt_q         <= '0;
      done_q        <= '0;
      resp_data_q   <= '0;
      resp_data_b_q <= '0;
      resp_err_q    <= 1'b0;
      busy_q        <= 1'b0;
      spi_wr_req_q  <= 1'b0;
      spi_rd_req_q  <= 1'b0;
      spi_data_q    <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (pick_any_d) begin
            idx_q      <= pick_idx_d;
            rd_q       <= bus.req_rd[pick_idx_d];
            spi_data_q <= bus.req_data[int'(pick_idx_d)*DATA_WITH +: DATA_WITH];
            gnt_q      <= ONE_HOT0 << pick_idx_d;
            busy_q     <= 1'b1;
            state_q    <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          gnt_q <= '0;
          // A stalled driver holds us here without any timeout.
          if (bus.spi_ready) begin
            spi_rd_req_q <= rd_q;
            spi_wr_req_q <= ~rd_q;
            cnt_q        <= 16'd0;
            state_q      <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          spi_wr_req_q <= 1'b0;
          spi_rd_req_q <= 1'b0;
          cnt_q        <= cnt_d;
          if (cmpl_s) begin
            if (rd_q) begin
              resp_data_q   <= bus.spi_rd_data;
              resp_data_b_q <= bus.spi_rd_data_b;
            end
            resp_err_q <= 1'b0;
            done_q     <= ONE_HOT0 << idx_q;
            state_q    <= ST_DONE;
          end else if (cnt_q == TIMEOUT - 16'd1) begin
            resp_data_q   <= '0;
            resp_data_b_q <= '0;
            resp_err_q    <= 1'b1;
            done_q        <= ONE_HOT0 << idx_q;
            state_q       <= ST_DONE;
          end
        end
        ST_DONE: begin
          done_q     <= '0;
          resp_err_q <= 1'b0;
          ptr_q      <= idx_q;
          busy_q     <= 1'b0;
          state_q    <= ST_IDLE;
        end
        default: begin
          gnt_q        <= '0;
          done_q       <= '0;
          busy_q       <= 1'b0;
          spi_wr_req_q <= 1'b0;
          spi_rd_req_q <= 1'b0;
          state_q      <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
